// File: rtl/cmac_fifo_pkg.sv
// Shared types and widths for the CMAC TX packet FIFO and its beat RAM.
package cmac_fifo_pkg;

  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = 64;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
  } axis_beat_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } drop_state_t;

endpackage

// File: rtl/cmac_sdp_ram.sv
// Simple dual-port beat RAM: one write port, one registered read port (1-cycle latency).
// The read register holds its value while rd_en is low.
module cmac_sdp_ram
  import cmac_fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  axis_beat_t    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output axis_beat_t    rd_data
);

  axis_beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cmac_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO ahead of the CMAC LBUS stage; oversize packets are dropped.
// Optional statistics counters are enabled by defining CMAC_TX_FIFO_STATS_EN.
module cmac_tx_pkt_fifo
  import cmac_fifo_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int MAX_BEATS = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [AXIS_DATA_W-1:0] S_AXIS_TDATA,
  input  logic [AXIS_KEEP_W-1:0] S_AXIS_TKEEP,
  input  logic                   S_AXIS_TLAST,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [AXIS_DATA_W-1:0] M_AXIS_TDATA,
  output logic [AXIS_KEEP_W-1:0] M_AXIS_TKEEP,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic [$clog2(DEPTH):0] PKT_COUNT,
  output logic [$clog2(DEPTH):0] FILL_LEVEL,
  output logic                   DROP_PULSE
`ifdef CMAC_TX_FIFO_STATS_EN
  ,
  output logic [31:0]            STAT_PKTS_OUT,
  output logic [31:0]            STAT_DROPS
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  drop_state_t state, state_next;
  logic [PW-1:0] wr_ptr, pkt_start, rd_ptr, out_ptr, pkt_count;
  logic [CW-1:0] beat_cnt;
  logic          full, s_ready, wr_hs, wr_en, commit, drop_now;
  logic          rd_en, ram_vld_p1, ram_take, out_vld_p2, out_hs;
  axis_beat_t    wr_beat, ram_beat_p1, out_beat_p2;

  // Space is only returned on egress handshake, so prefetched beats still occupy their slots.
  assign full    = (wr_ptr[AW] != out_ptr[AW]) && (wr_ptr[AW-1:0] == out_ptr[AW-1:0]);
  assign s_ready = (!full || state == DROP) && !RST;
  assign wr_hs   = S_AXIS_TVALID && s_ready;
  assign wr_beat = '{tdata: S_AXIS_TDATA, tkeep: S_AXIS_TKEEP, tlast: S_AXIS_TLAST};

  always_ff @(posedge CLK) begin
    if (RST) state <= ACCEPT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop_now   = 1'b0;
    case (state)
      ACCEPT: begin
        if (wr_hs) begin
          wr_en = 1'b1;
          if (S_AXIS_TLAST) begin
            commit = 1'b1;
          end else if (beat_cnt == LAST_CNT) begin
            drop_now   = 1'b1;
            state_next = DROP;
          end
        end
      end
      DROP: begin
        if (wr_hs && S_AXIS_TLAST) state_next = ACCEPT;
      end
      default: state_next = ACCEPT;
    endcase
  end

  // Write side: pkt_start marks the boundary between committed beats and the open packet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      pkt_start <= '0;
      beat_cnt  <= '0;
    end else if (wr_en) begin
      if (commit) begin
        wr_ptr    <= wr_ptr + PW'(1);
        pkt_start <= wr_ptr + PW'(1);
        beat_cnt  <= '0;
      end else if (drop_now) begin
        wr_ptr   <= pkt_start;
        beat_cnt <= '0;
      end else begin
        wr_ptr   <= wr_ptr + PW'(1);
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

  cmac_sdp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_beat_p1)
  );

  // p1: RAM read register; p2: output register. Each stage advances only when the next frees.
  assign out_hs   = out_vld_p2 && M_AXIS_TREADY;
  assign ram_take = ram_vld_p1 && (!out_vld_p2 || out_hs);
  assign rd_en    = (rd_ptr != pkt_start) && (!ram_vld_p1 || ram_take);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr      <= '0;
      out_ptr     <= '0;
      ram_vld_p1  <= 1'b0;
      out_vld_p2  <= 1'b0;
      out_beat_p2 <= '0;
    end else begin
      if (rd_en)  rd_ptr  <= rd_ptr + PW'(1);
      if (out_hs) out_ptr <= out_ptr + PW'(1);
      if (rd_en)         ram_vld_p1 <= 1'b1;
      else if (ram_take) ram_vld_p1 <= 1'b0;
      if (ram_take) begin
        out_vld_p2  <= 1'b1;
        out_beat_p2 <= ram_beat_p1;
      end else if (out_hs) begin
        out_vld_p2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) pkt_count <= '0;
    else begin
      case ({commit, out_hs && out_beat_p2.tlast})
        2'b10:   pkt_count <= pkt_count + PW'(1);
        2'b01:   pkt_count <= pkt_count - PW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = out_vld_p2 && !RST;
  assign M_AXIS_TDATA  = out_beat_p2.tdata;
  assign M_AXIS_TKEEP  = out_beat_p2.tkeep;
  assign M_AXIS_TLAST  = out_beat_p2.tlast;
  assign PKT_COUNT     = pkt_count;
  assign FILL_LEVEL    = wr_ptr - out_ptr;
  assign DROP_PULSE    = drop_now;

`ifdef CMAC_TX_FIFO_STATS_EN
  logic [31:0] stat_pkts, stat_drops;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_pkts  <= '0;
      stat_drops <= '0;
    end else begin
      if (out_hs && out_beat_p2.tlast && stat_pkts != '1) stat_pkts  <= stat_pkts + 32'd1;
      if (drop_now && stat_drops != '1)                   stat_drops <= stat_drops + 32'd1;
    end
  end

  assign STAT_PKTS_OUT = stat_pkts;
  assign STAT_DROPS    = stat_drops;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cmac_tx_pkt_fifo.sv
// Bench for cmac_tx_pkt_fifo: a 64/64 instance and a 16/8 instance share one stimulus set,
// with sel choosing which one is driven and observed.
module tb_cmac_tx_pkt_fifo;
  import cmac_fifo_pkg::*;

  localparam int LIM = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sel;
  logic [511:0] s_tdata;
  logic [63:0]  s_tkeep;
  logic         s_tlast, s_tvalid, m_tready;

  logic         s_tready_b, m_tlast_b, m_tvalid_b, drop_b;
  logic [511:0] m_tdata_b;
  logic [63:0]  m_tkeep_b;
  logic [6:0]   pc_b, fill_b;
  logic         s_tready_s, m_tlast_s, m_tvalid_s, drop_s;
  logic [511:0] m_tdata_s;
  logic [63:0]  m_tkeep_s;
  logic [4:0]   pc_s, fill_s;

  logic         s_tready, m_tvalid, m_tlast, drop_pulse;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic [6:0]   pkt_count, fill;
  axis_beat_t   m_beat;

  int total = 0;
  int bad   = 0;
  axis_beat_t exp_q[$];

  cmac_tx_pkt_fifo #(.DEPTH(64), .MAX_BEATS(64)) u_big (
    .CLK(clk), .RST(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid & ~sel), .S_AXIS_TREADY(s_tready_b),
    .M_AXIS_TDATA(m_tdata_b), .M_AXIS_TKEEP(m_tkeep_b), .M_AXIS_TLAST(m_tlast_b),
    .M_AXIS_TVALID(m_tvalid_b), .M_AXIS_TREADY(m_tready & ~sel),
    .PKT_COUNT(pc_b), .FILL_LEVEL(fill_b), .DROP_PULSE(drop_b)
  );

  cmac_tx_pkt_fifo #(.DEPTH(16), .MAX_BEATS(8)) u_small (
    .CLK(clk), .RST(rst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid & sel), .S_AXIS_TREADY(s_tready_s),
    .M_AXIS_TDATA(m_tdata_s), .M_AXIS_TKEEP(m_tkeep_s), .M_AXIS_TLAST(m_tlast_s),
    .M_AXIS_TVALID(m_tvalid_s), .M_AXIS_TREADY(m_tready & sel),
    .PKT_COUNT(pc_s), .FILL_LEVEL(fill_s), .DROP_PULSE(drop_s)
  );

  assign s_tready   = sel ? s_tready_s : s_tready_b;
  assign m_tvalid   = sel ? m_tvalid_s : m_tvalid_b;
  assign m_tlast    = sel ? m_tlast_s  : m_tlast_b;
  assign m_tdata    = sel ? m_tdata_s  : m_tdata_b;
  assign m_tkeep    = sel ? m_tkeep_s  : m_tkeep_b;
  assign drop_pulse = sel ? drop_s     : drop_b;
  assign pkt_count  = sel ? {2'b00, pc_s}   : pc_b;
  assign fill       = sel ? {2'b00, fill_s} : fill_b;
  assign m_beat     = {m_tdata, m_tkeep, m_tlast};

  function automatic axis_beat_t rand_beat(input bit last);
    axis_beat_t b;
    for (int i = 0; i < 16; i++) b.tdata[i*32 +: 32] = $urandom;
    b.tkeep = last ? ({64{1'b1}} >> $urandom_range(0, 63)) : {64{1'b1}};
    b.tlast = last;
    return b;
  endfunction

  // Presents one beat and holds it until accepted; reports DROP_PULSE seen in the accept cycle.
  task automatic put_beat(input axis_beat_t b, output logic dp, output int w);
    s_tdata = b.tdata; s_tkeep = b.tkeep; s_tlast = b.tlast; s_tvalid = 1'b1; w = 0;
    @(negedge clk);
    while (!s_tready && w < LIM) begin @(negedge clk); w++; end
    dp = drop_pulse;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic get_beat(output axis_beat_t b, output bit ok);
    int c = 0;
    ok = 1'b0;
    b  = '0;
    while (!ok && c < LIM) begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin b = m_beat; ok = 1'b1; end
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
    s_tdata = '0; s_tkeep = '1;
    @(negedge clk);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%0b exp=0", s_tready); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%0b exp=0", m_tvalid); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL rst_drop got=%0b exp=0", drop_pulse); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    total++; if (pkt_count !== 7'd0) begin bad++; $display("FAIL rst_pktcnt got=%0d exp=0", pkt_count); end
    total++; if (fill !== 7'd0) begin bad++; $display("FAIL rst_fill got=%0d exp=0", fill); end
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%0b exp=1", s_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    axis_beat_t b;
    logic dp;
    int w;
    sel = 1'b0; m_tready = 1'b1;
    b = rand_beat(1'b1); b.tkeep = 64'hFF;
    put_beat(b, dp, w);
    total++; if (w >= LIM) begin bad++; $display("FAIL single_accept got=%0d exp<%0d", w, LIM); end
    @(negedge clk);
    total++; if (pkt_count !== 7'd1) begin bad++; $display("FAIL single_pktcnt1 got=%0d exp=1", pkt_count); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_early0 got=%0b exp=0", m_tvalid); end
    @(negedge clk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_early1 got=%0b exp=0", m_tvalid); end
    @(negedge clk);
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", m_tvalid); end
    total++; if (m_beat !== b) begin bad++; $display("FAIL single_beat got=%0h exp=%0h", m_beat, b); end
    @(negedge clk);
    total++; if (pkt_count !== 7'd0) begin bad++; $display("FAIL single_pktcnt0 got=%0d exp=0", pkt_count); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_after got=%0b exp=0", m_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_five_beat();
    axis_beat_t p[5];
    logic dp;
    int w, lat;
    sel = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 5; i++) p[i] = rand_beat(i == 4);
    for (int i = 0; i < 5; i++) begin
      put_beat(p[i], dp, w);
      if (i < 4) begin
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL five_hold%0d got=%0b exp=0", i, m_tvalid); end
        @(posedge clk); #1;
      end
    end
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_tvalid) begin lat = c; break; end
    end
    total++; if (lat != 2) begin bad++; $display("FAIL five_latency got=%0d exp=2", lat); end
    for (int i = 0; i < 5; i++) begin
      total++; if (!m_tvalid || m_beat !== p[i]) begin bad++; $display("FAIL five_beat%0d got=%0h exp=%0h", i, m_beat, p[i]); end
      @(negedge clk);
    end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL five_end got=%0b exp=0", m_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    axis_beat_t b, g;
    logic dp;
    int w, extra;
    bit ok;
    sel = 1'b1; m_tready = 1'b1; exp_q.delete();
    // Ten beats exceed the eight-beat limit: the eighth beat triggers the drop.
    for (int i = 0; i < 10; i++) begin
      b = rand_beat(i == 9);
      put_beat(b, dp, w);
      total++; if (dp !== (i == 7)) begin bad++; $display("FAIL drop_pulse%0d got=%0b exp=%0b", i, dp, (i == 7)); end
    end
    @(negedge clk);
    total++; if (fill !== 7'd0) begin bad++; $display("FAIL drop_fill got=%0d exp=0", fill); end
    total++; if (pkt_count !== 7'd0) begin bad++; $display("FAIL drop_pktcnt got=%0d exp=0", pkt_count); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      b = rand_beat(i == 2);
      exp_q.push_back(b);
      put_beat(b, dp, w);
    end
    for (int i = 0; i < 3; i++) begin
      get_beat(g, ok);
      total++; if (!ok || g !== exp_q[i]) begin bad++; $display("FAIL drop_rx%0d got=%0h exp=%0h", i, g, exp_q[i]); end
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (m_tvalid) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL drop_extra got=%0d exp=0", extra); end
    total++; if (fill !== 7'd0) begin bad++; $display("FAIL drop_fill_end got=%0d exp=0", fill); end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    axis_beat_t b, g;
    logic dp;
    int w;
    bit ok;
    sel = 1'b0; m_tready = 1'b0; exp_q.delete();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) begin
        b = rand_beat(i == 15);
        exp_q.push_back(b);
        put_beat(b, dp, w);
      end
    @(negedge clk);
    total++; if (fill !== 7'd64) begin bad++; $display("FAIL full_fill got=%0d exp=64", fill); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", s_tready); end
    total++; if (pkt_count !== 7'd4) begin bad++; $display("FAIL full_pktcnt got=%0d exp=4", pkt_count); end
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      get_beat(g, ok);
      total++; if (!ok || g !== exp_q[i]) begin bad++; $display("FAIL full_rx%0d got=%0h exp=%0h", i, g, exp_q[i]); end
    end
    @(negedge clk);
    total++; if (fill !== 7'd0) begin bad++; $display("FAIL full_fill_end got=%0d exp=0", fill); end
    total++; if (pkt_count !== 7'd0) begin bad++; $display("FAIL full_pktcnt_end got=%0d exp=0", pkt_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_same_cycle();
    axis_beat_t a, b, g;
    logic dp;
    int w;
    bit ok;
    sel = 1'b0; m_tready = 1'b0;
    a = rand_beat(1'b1); b = rand_beat(1'b1);
    put_beat(a, dp, w);
    repeat (3) @(negedge clk);
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL same_head got=%0b exp=1", m_tvalid); end
    @(posedge clk); #1;
    m_tready = 1'b1;
    s_tdata = b.tdata; s_tkeep = b.tkeep; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(negedge clk);
    total++; if (!(s_tready && m_tvalid)) begin bad++; $display("FAIL same_both got=%0b%0b exp=11", s_tready, m_tvalid); end
    total++; if (m_beat !== a) begin bad++; $display("FAIL same_a got=%0h exp=%0h", m_beat, a); end
    total++; if (pkt_count !== 7'd1) begin bad++; $display("FAIL same_before got=%0d exp=1", pkt_count); end
    @(posedge clk); #1;
    s_tvalid = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    total++; if (pkt_count !== 7'd1) begin bad++; $display("FAIL same_after got=%0d exp=1", pkt_count); end
    @(posedge clk); #1;
    m_tready = 1'b1;
    get_beat(g, ok);
    total++; if (!ok || g !== b) begin bad++; $display("FAIL same_b got=%0h exp=%0h", g, b); end
    @(negedge clk);
    total++; if (pkt_count !== 7'd0) begin bad++; $display("FAIL same_drain got=%0d exp=0", pkt_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_ready();
    axis_beat_t sq[$];
    int n;
    sel = 1'b0; m_tready = 1'b0; exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) sq.push_back(rand_beat(i == len - 1));
    end
    // Every packet is within the size limit, so the egress stream equals the ingress stream.
    foreach (sq[i]) exp_q.push_back(sq[i]);
    n = sq.size();
    fork
      begin
        logic dp;
        int w;
        foreach (sq[i]) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          put_beat(sq[i], dp, w);
        end
      end
      begin
        int got = 0, guard = 0;
        bit stalled = 1'b0;
        axis_beat_t held = '0;
        while (got < n && guard < 4 * LIM) begin
          m_tready = ($urandom_range(0, 1) == 1);
          @(negedge clk);
          if (stalled) begin
            total++; if (!m_tvalid || m_beat !== held) begin bad++; $display("FAIL rnd_stall v=%0b got=%0h exp=%0h", m_tvalid, m_beat, held); end
          end
          if (m_tvalid && m_tready) begin
            total++; if (m_beat !== exp_q[got]) begin bad++; $display("FAIL rnd_rx%0d got=%0h exp=%0h", got, m_beat, exp_q[got]); end
            got++; stalled = 1'b0;
          end else if (m_tvalid) begin
            stalled = 1'b1; held = m_beat;
          end
          @(posedge clk); #1;
          guard++;
        end
        total++; if (got != n) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got, n); end
      end
    join
    m_tready = 1'b0;
    @(negedge clk);
    total++; if (fill !== 7'd0) begin bad++; $display("FAIL rnd_fill got=%0d exp=0", fill); end
    total++; if (pkt_count !== 7'd0) begin bad++; $display("FAIL rnd_pktcnt got=%0d exp=0", pkt_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    axis_beat_t b, g, q[4];
    logic dp;
    int w, extra;
    bit ok;
    sel = 1'b0; m_tready = 1'b0;
    for (int i = 0; i < 2; i++) put_beat(rand_beat(i == 1), dp, w);
    for (int i = 0; i < 3; i++) put_beat(rand_beat(1'b0), dp, w);
    rst = 1'b1;
    @(negedge clk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b exp=0", m_tvalid); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=0", s_tready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", m_tvalid); end
    total++; if (pkt_count !== 7'd0) begin bad++; $display("FAIL mid_pktcnt got=%0d exp=0", pkt_count); end
    total++; if (fill !== 7'd0) begin bad++; $display("FAIL mid_fill got=%0d exp=0", fill); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL mid_drop got=%0b exp=0", drop_pulse); end
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = rand_beat(i == 3); q[i] = b;
      put_beat(b, dp, w);
    end
    for (int i = 0; i < 4; i++) begin
      get_beat(g, ok);
      total++; if (!ok || g !== q[i]) begin bad++; $display("FAIL mid_rx%0d got=%0h exp=%0h", i, g, q[i]); end
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (m_tvalid) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL mid_extra got=%0d exp=0", extra); end
    total++; if (fill !== 7'd0) begin bad++; $display("FAIL mid_fill_end got=%0d exp=0", fill); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_five_beat();
    test_drop();
    test_full();
    test_same_cycle();
    test_random_ready();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
